fpga_lut4: RTL and testbench

// - One 4-input lookup table (LUT4) cell for the soft-FPGA fabric; leaf element instantiated by CLB/logic-tile wrappers.
// - Holds a 16-bit truth table loaded through a simple write port.
// - out_o = truth_table[in_i]; in_i is the 4-bit LUT input vector.

---
 rtl/fpga_lut_pkg.sv | 20 ++
 rtl/lut4_mux.sv | 30 +++
 rtl/fpga_lut4.sv | 61 ++++++
 tb/tb_fpga_lut4.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fpga_lut_pkg.sv
// Shared types and constants for the soft-FPGA LUT cells.
// lut_level_base() gives the offset of each level in a flattened
// binary mux tree: level 0 holds the table bits, the last level is the root.
package fpga_lut_pkg;

  localparam int LUT_K     = 4;
  localparam int LUT_SIZE  = 16;
  localparam int LUT_NODES = 2 * LUT_SIZE - 1;

  typedef logic [LUT_SIZE-1:0] lut_cfg_t;
  typedef logic [LUT_K-1:0]    lut_sel_t;

  localparam lut_cfg_t LUT_INIT_ZERO = '0;

  // Base index of a tree level: 0, 16, 24, 28, 30 for a 16-entry table.
  function automatic int lut_level_base(input int level);
    return (2 * LUT_SIZE) - ((2 * LUT_SIZE) >> level);
  endfunction

endpackage

// File: rtl/lut4_mux.sv
// 16:1 selector built as an explicit tree of 2:1 muxes.
// Level k (16->8->4->2->1) is steered by sel_i[k], so sel_i[0] picks
// between adjacent table bits and sel_i[3] makes the final choice.
module lut4_mux
  import fpga_lut_pkg::*;
(
  input  lut_cfg_t cfg_i,
  input  lut_sel_t sel_i,
  output logic     out_o
);

  // All tree nodes in one vector; each level is packed after the previous one.
  logic [LUT_NODES-1:0] node;

  assign node[LUT_SIZE-1:0] = cfg_i;

  for (genvar gi = 0; gi < LUT_K; gi++) begin : g_level
    localparam int IN_BASE  = lut_level_base(gi);
    localparam int OUT_BASE = lut_level_base(gi + 1);
    localparam int WIDTH    = LUT_SIZE >> (gi + 1);

    for (genvar gj = 0; gj < WIDTH; gj++) begin : g_mux
      assign node[OUT_BASE + gj] = sel_i[gi] ? node[IN_BASE + 2 * gj + 1]
                                             : node[IN_BASE + 2 * gj];
    end
  end

  assign out_o = node[LUT_NODES-1];

endmodule

// File: rtl/fpga_lut4.sv
// Single LUT4 cell: 16-bit truth table with a write port, readback and a
// "configured since reset" flag.
// Optional macro FPGA_LUT4_REG_OUT_EN registers out_o (one cycle latency,
// out_o resets to 0); without it out_o is combinational from in_i and the table.
module fpga_lut4
  import fpga_lut_pkg::*;
#(
  parameter lut_cfg_t INIT_VALUE = LUT_INIT_ZERO
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [LUT_SIZE-1:0] data_in_i,
  input  logic                data_we_i,
  input  logic [LUT_K-1:0]    in_i,
  output logic                out_o,
  output logic [LUT_SIZE-1:0] cfg_o,
  output logic                cfg_valid_o
);

  lut_cfg_t cfg_reg;
  logic     cfg_valid_reg;
  logic     mux_out;

  // Truth table and valid flag: reset restores INIT_VALUE, a write overrides it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cfg_reg       <= INIT_VALUE;
      cfg_valid_reg <= 1'b0;
    end else if (data_we_i) begin
      cfg_reg       <= data_in_i;
      cfg_valid_reg <= 1'b1;
    end
  end

  lut4_mux u_mux (
    .cfg_i (cfg_reg),
    .sel_i (in_i),
    .out_o (mux_out)
  );

`ifdef FPGA_LUT4_REG_OUT_EN
  logic out_q;

  // Output flop: samples the table as it stood before any write on this edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_q <= 1'b0;
    end else begin
      out_q <= mux_out;
    end
  end

  assign out_o = out_q;
`else
  assign out_o = mux_out;
`endif

  assign cfg_o       = cfg_reg;
  assign cfg_valid_o = cfg_valid_reg;

endmodule

// File: tb/tb_fpga_lut4.sv
// Self-checking bench for fpga_lut4: directed steps followed by random
// writes/reads, checked against a simple table model held in the bench.
// Handles both the combinational and the registered-output build.
module tb_fpga_lut4;

  localparam logic [15:0] INIT = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] data_in_i;
  logic        data_we_i;
  logic [3:0]  in_i;
  logic        out_o;
  logic [15:0] cfg_o;
  logic        cfg_valid_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the table as a plain 16-bit word plus the valid flag.
  logic [15:0] model_cfg;
  logic        model_valid;

  always #5 clk = ~clk;

  fpga_lut4 #(.INIT_VALUE(INIT)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .data_in_i   (data_in_i),
    .data_we_i   (data_we_i),
    .in_i        (in_i),
    .out_o       (out_o),
    .cfg_o       (cfg_o),
    .cfg_valid_o (cfg_valid_o)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  // Apply a select and check out_o once it is valid for the build in use.
  task automatic check_out(input string tag, input logic [3:0] sel);
    logic exp;
    in_i = sel;
    exp  = model_cfg[sel];
`ifdef FPGA_LUT4_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    $display("read  %s in=%h out=%b exp=%b", tag, sel, out_o, exp);
    check(tag, {15'd0, out_o}, {15'd0, exp});
  endtask

  task automatic write_tbl(input logic [15:0] d);
    data_in_i = d;
    data_we_i = 1'b1;
    @(posedge clk);
    #1;
    data_we_i   = 1'b0;
    model_cfg   = d;
    model_valid = 1'b1;
    $display("write cfg=%h", d);
    check("wr_cfg", cfg_o, model_cfg);
    check("wr_valid", {15'd0, cfg_valid_o}, {15'd0, model_valid});
  endtask

  initial begin
    int sel_list[$];
    logic [15:0] prev_cfg;
    logic        exp_out;

    reset_i   = 1'b1;
    data_in_i = '0;
    data_we_i = 1'b0;
    in_i      = '0;
    model_cfg   = INIT;
    model_valid = 1'b0;

    // Reset state, observed while reset is still held.
    #12;
    $display("reset held");
    check("rst_cfg", cfg_o, INIT);
    check("rst_valid", {15'd0, cfg_valid_o}, 16'd0);
    check("rst_out", {15'd0, out_o}, 16'd0);
    @(negedge clk);
    reset_i = 1'b0;

    for (int i = 0; i < 16; i++) check_out("rst_sweep", 4'(i));

    // Load 0x00F0 and sweep the interesting indices.
    write_tbl(16'h00F0);
    sel_list = '{0, 1, 2, 4, 5, 6, 7, 8, 15};
    foreach (sel_list[k]) check_out("f0_sweep", 4'(sel_list[k]));

    // One-hot decoder checks at both ends of the table.
    write_tbl(16'h8000);
    for (int i = 0; i < 16; i++) check_out("dec_msb", 4'(i));
    write_tbl(16'h0001);
    for (int i = 0; i < 16; i++) check_out("dec_lsb", 4'(i));

    // Reset and write at the same edge: reset wins.
    data_in_i = 16'hFFFF;
    data_we_i = 1'b1;
    reset_i   = 1'b1;
    @(posedge clk);
    #1;
    model_cfg   = INIT;
    model_valid = 1'b0;
    $display("reset+write collision");
    check("coll_cfg", cfg_o, INIT);
    check("coll_valid", {15'd0, cfg_valid_o}, 16'd0);
    @(negedge clk);
    data_we_i = 1'b0;
    reset_i   = 1'b0;

    // Asynchronous reset between edges takes effect without a clock.
    write_tbl(16'hAAAA);
    #2;
    reset_i = 1'b1;
    #1;
    model_cfg   = INIT;
    model_valid = 1'b0;
    $display("async reset mid-cycle");
    check("async_cfg", cfg_o, INIT);
    check("async_valid", {15'd0, cfg_valid_o}, 16'd0);
    @(negedge clk);
    reset_i = 1'b0;

`ifdef FPGA_LUT4_REG_OUT_EN
    // Registered output: one edge of latency, old table on a same-cycle write.
    write_tbl(16'h00F0);
    in_i = 4'h0;
    @(posedge clk);
    #1;
    check("lat_before", {15'd0, out_o}, 16'd0);
    in_i = 4'h4;
    #1;
    check("lat_hold", {15'd0, out_o}, 16'd0);
    @(posedge clk);
    #1;
    $display("latency in=4 out=%b", out_o);
    check("lat_after", {15'd0, out_o}, 16'd1);
    write_tbl(16'h0000);
    check("same_cyc_old", {15'd0, out_o}, 16'd1);
    @(posedge clk);
    #1;
    check("same_cyc_new", {15'd0, out_o}, 16'd0);
`endif

    // Random writes, reads and occasional mid-cycle resets.
    for (int n = 0; n < 300; n++) begin
      data_in_i = 16'($urandom);
      data_we_i = 1'($urandom_range(0, 1));
      in_i      = 4'($urandom_range(0, 15));
      prev_cfg  = model_cfg;
      @(posedge clk);
      #1;
      if (data_we_i) begin
        model_cfg   = data_in_i;
        model_valid = 1'b1;
      end
`ifdef FPGA_LUT4_REG_OUT_EN
      exp_out = prev_cfg[in_i];
`else
      exp_out = model_cfg[in_i];
`endif
      $display("rand  n=%0d we=%b d=%h in=%h cfg=%h out=%b exp_out=%b",
               n, data_we_i, data_in_i, in_i, cfg_o, out_o, exp_out);
      check("rand_cfg", cfg_o, model_cfg);
      check("rand_valid", {15'd0, cfg_valid_o}, {15'd0, model_valid});
      check("rand_out", {15'd0, out_o}, {15'd0, exp_out});
      if ($urandom_range(0, 19) == 0) begin
        data_we_i = 1'b0;
        reset_i   = 1'b1;
        #1;
        model_cfg   = INIT;
        model_valid = 1'b0;
        $display("rand  reset pulse");
        check("rand_rst_cfg", cfg_o, INIT);
        check("rand_rst_valid", {15'd0, cfg_valid_o}, 16'd0);
        @(negedge clk);
        reset_i = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
